// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS main control FSM.
//   - instruction opcodes (IR[31:26])
//   - FSM state encodings (also exported on the debug state port)
//   - alu_op codes consumed by the ALU control decoder
//   - datapath mux-select encodings (pc_src, reg_dst, wb_sel, alu_src_b)
//   - an opcode classifier used by the FSM
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ALU_R   = 3'd0,
    ALU_BEQ = 3'd1,
    ALU_ORI = 3'd2,
    ALU_LW  = 3'd3,
    ALU_SW  = 3'd4,
    ALU_JAL = 3'd5,
    ALU_JMP = 3'd6
  } alu_op_t;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  localparam logic [1:0] ALUB_RT   = 2'd0;
  localparam logic [1:0] ALUB_ZIMM = 2'd1;
  localparam logic [1:0] ALUB_SIMM = 2'd2;

  // Instruction class seen by the FSM; INS_BAD covers every unsupported opcode.
  typedef enum logic [2:0] {
    INS_R, INS_ORI, INS_LW, INS_SW, INS_BEQ, INS_J, INS_JAL, INS_BAD
  } ins_t;

  function automatic ins_t decode_op(input logic [5:0] op);
    ins_t r;
    case (op)
      OP_R:    r = INS_R;
      OP_ORI:  r = INS_ORI;
      OP_LW:   r = INS_LW;
      OP_SW:   r = INS_SW;
      OP_BEQ:  r = INS_BEQ;
      OP_J:    r = INS_J;
      OP_JAL:  r = INS_JAL;
      default: r = INS_BAD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM for the MIPS core. Sequences the
// shared ALU, register file, PC/IR and a single unified memory port, with an
// optional mem_ready watchdog.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode                IR[31:26], stable from the cycle after ir_write
//   zero                  ALU zero flag (beq)
//   mem_ready             memory completes the current request this cycle
//   mem_req/mem_we/iord   memory request, write enable, address select
//   ir_write, pc_write    IR / PC load enables
//   pc_src                0=PC+4, 1=branch target, 2=jump target
//   reg_write, reg_dst    register write, 0=rt 1=rd 2=$31
//   wb_sel                0=ALU result, 1=memory data, 2=current PC
//   alu_src_b             0=rt, 1=zero-ext imm, 2=sign-ext imm
//   alu_op                code for the ALU control decoder
//   retire                pulse in an instruction's last cycle
//   halted, mem_timeout   sticky halt flag and watchdog cause
//   state                 debug view of the FSM state
//
// State table:
//   state  | meaning
//   IDLE   | out of reset, all outputs 0
//   FETCH  | read instruction at PC, wait for mem_ready, load IR and PC+4
//   DECODE | classify opcode; unsupported -> HALT
//   EXEC   | ALU operation / branch / jump resolution
//   MEM    | data access for lw/sw at the ALU result address
//   WB     | register file write-back, retire
//   HALT   | stopped until reset (illegal opcode or watchdog)
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 3,
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                retire,
  output logic                halted,
  output logic                mem_timeout,
  output logic [2:0]          state
);

  // The limit cycle is the one in which the count of non-ready cycles would
  // reach WAIT_LIMIT, i.e. the counter currently holds WAIT_LIMIT-1.
  localparam logic [CNT_W-1:0] LIMIT_M1 =
    (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  ins_t             ins;
  logic             mem_phase;
  logic             limit_hit;
  alu_op_t          alu_code;

  assign ins       = decode_op(opcode);
  assign mem_phase = (st_q == ST_FETCH) || (st_q == ST_MEM);
  // mem_ready in the limit cycle takes priority over the timeout.
  assign limit_hit = (WAIT_LIMIT > 0) && mem_phase && !mem_ready &&
                     (wait_cnt_q == LIMIT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:   st_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)      st_d = ST_DECODE;
        else if (limit_hit) st_d = ST_HALT;
      end
      ST_DECODE: st_d = (ins == INS_BAD) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (ins)
          INS_R, INS_ORI: st_d = ST_WB;
          INS_LW, INS_SW: st_d = ST_MEM;
          default:        st_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)      st_d = (ins == INS_LW) ? ST_WB : ST_FETCH;
        else if (limit_hit) st_d = ST_HALT;
      end
      ST_WB:     st_d = ST_FETCH;
      ST_HALT:   st_d = ST_HALT;
      default:   st_d = ST_HALT;
    endcase

    // Staying in FETCH/MEM only happens on a non-ready cycle; any other
    // transition (including re-entry from another state) restarts the count.
    wait_cnt_d = (mem_phase && (st_d == st_q)) ? wait_cnt_q + 1'b1 : '0;
    timeout_d  = timeout_q | limit_hit;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PC4;
    reg_write = 1'b0;
    reg_dst   = REG_DST_RT;
    wb_sel    = WB_SEL_ALU;
    alu_src_b = ALUB_RT;
    alu_code  = ALU_R;
    retire    = 1'b0;
    halted    = 1'b0;
    case (st_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_PC4;
        end
      end
      ST_EXEC: begin
        case (ins)
          INS_R: begin
            alu_src_b = ALUB_RT;
            alu_code  = ALU_R;
          end
          INS_ORI: begin
            alu_src_b = ALUB_ZIMM;
            alu_code  = ALU_ORI;
          end
          INS_LW: begin
            alu_src_b = ALUB_SIMM;
            alu_code  = ALU_LW;
          end
          INS_SW: begin
            alu_src_b = ALUB_SIMM;
            alu_code  = ALU_SW;
          end
          INS_BEQ: begin
            alu_code = ALU_BEQ;
            pc_src   = PC_SRC_BR;
            pc_write = zero;
            retire   = 1'b1;
          end
          INS_J: begin
            alu_code = ALU_JMP;
            pc_src   = PC_SRC_JMP;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          INS_JAL: begin
            // PC already holds PC+4 here, so it is the link value.
            alu_code  = ALU_JAL;
            pc_src    = PC_SRC_JMP;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            reg_dst   = REG_DST_RA;
            wb_sel    = WB_SEL_PC;
            retire    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (ins == INS_SW);
        retire  = mem_ready && (ins == INS_SW);
      end
      ST_WB: begin
        retire    = 1'b1;
        reg_write = 1'b1;
        case (ins)
          INS_R: begin
            reg_dst = REG_DST_RD;
            wb_sel  = WB_SEL_ALU;
          end
          INS_ORI: begin
            reg_dst = REG_DST_RT;
            wb_sel  = WB_SEL_ALU;
          end
          INS_LW: begin
            reg_dst = REG_DST_RT;
            wb_sel  = WB_SEL_MEM;
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign alu_op      = ALU_OP_W'(alu_code);
  assign mem_timeout = timeout_q;
  assign state       = st_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction streams for mc_ctrl (WAIT_LIMIT=4), with a
// second instance (WAIT_LIMIT=0) sharing the inputs to show the watchdog off.
// The stimulus expands each instruction into its expected per-cycle control
// vectors and queues them; a negedge monitor pops and compares.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, retire;
  logic       halted, mem_timeout;
  logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b;
  logic [2:0] alu_op, state;

  logic       d0_mem_req, d0_mem_we, d0_iord, d0_ir_write, d0_pc_write;
  logic       d0_reg_write, d0_retire, d0_halted, d0_mem_timeout;
  logic [1:0] d0_pc_src, d0_reg_dst, d0_wb_sel, d0_alu_src_b;
  logic [2:0] d0_alu_op, d0_state;

  mc_ctrl #(.ALU_OP_W(3), .WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .halted(halted), .mem_timeout(mem_timeout), .state(state)
  );

  mc_ctrl #(.ALU_OP_W(3), .WAIT_LIMIT(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(d0_mem_req), .mem_we(d0_mem_we),
    .iord(d0_iord), .ir_write(d0_ir_write), .pc_write(d0_pc_write),
    .pc_src(d0_pc_src), .reg_write(d0_reg_write), .reg_dst(d0_reg_dst),
    .wb_sel(d0_wb_sel), .alu_src_b(d0_alu_src_b), .alu_op(d0_alu_op),
    .retire(d0_retire), .halted(d0_halted), .mem_timeout(d0_mem_timeout),
    .state(d0_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, wb_sel, alu_src_b;
    logic [2:0] alu_op;
    logic       retire, halted, mem_timeout;
  } ovec_t;

  ovec_t exp_q[$];
  int    total = 0;
  int    bad = 0;

  always @(negedge clk) begin
    ovec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '0;
      a.st = state;         a.mem_req = mem_req;     a.mem_we = mem_we;
      a.iord = iord;        a.ir_write = ir_write;   a.pc_write = pc_write;
      a.pc_src = pc_src;    a.reg_write = reg_write; a.reg_dst = reg_dst;
      a.wb_sel = wb_sel;    a.alu_src_b = alu_src_b; a.alu_op = alu_op;
      a.retire = retire;    a.halted = halted;       a.mem_timeout = mem_timeout;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctl_vec t=%0t actual=%h required=%h (st %0d vs %0d)",
                 $time, a, e, a.st, e.st);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ovec_t vec(input logic [2:0] s);
    ovec_t v;
    v = '0;
    v.st = s;
    if (s == 3'd6) v.halted = 1'b1;
    return v;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for this cycle.
  task automatic cyc(input logic rdy, input logic z, input ovec_t e);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Memory access phase: w non-ready cycles then ready. The watchdog fires on
  // the LIMIT-th non-ready cycle. Returns 1 if the access ended in a halt.
  task automatic access(input ovec_t wait_v, input ovec_t rdy_v, input int w,
                        output bit halted_out);
    ovec_t h;
    halted_out = 0;
    for (int i = 0; i < w; i++) begin
      cyc(1'b0, rb(), wait_v);
      if (i == LIMIT - 1) begin
        h = vec(3'd6);
        h.mem_timeout = 1'b1;
        repeat (3) cyc(1'b0, rb(), h);
        halted_out = 1;
        return;
      end
    end
    cyc(1'b1, rb(), rdy_v);
  endtask

  // Whole instruction starting in FETCH: wf/wm wait cycles, z = ALU zero in EXEC.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input logic z);
    ovec_t v, r;
    bit    h;
    v = vec(3'd1); v.mem_req = 1'b1;
    r = v; r.ir_write = 1'b1; r.pc_write = 1'b1; r.pc_src = 2'd0;
    access(v, r, wf, h);
    if (h) return;
    opcode = op;
    cyc(rb(), rb(), vec(3'd2));
    if (!is_legal(op)) begin
      repeat (3) cyc(rb(), rb(), vec(3'd6));
      return;
    end
    v = vec(3'd3);
    case (op)
      OP_R:   begin v.alu_src_b = 2'd0; v.alu_op = 3'd0; end
      OP_ORI: begin v.alu_src_b = 2'd1; v.alu_op = 3'd2; end
      OP_LW:  begin v.alu_src_b = 2'd2; v.alu_op = 3'd3; end
      OP_SW:  begin v.alu_src_b = 2'd2; v.alu_op = 3'd4; end
      OP_BEQ: begin v.alu_op = 3'd1; v.pc_src = 2'd1; v.pc_write = z; v.retire = 1'b1; end
      OP_J:   begin v.alu_op = 3'd6; v.pc_src = 2'd2; v.pc_write = 1'b1; v.retire = 1'b1; end
      default: begin
        v.alu_op = 3'd5; v.pc_src = 2'd2; v.pc_write = 1'b1; v.retire = 1'b1;
        v.reg_write = 1'b1; v.reg_dst = 2'd2; v.wb_sel = 2'd2;
      end
    endcase
    cyc(rb(), z, v);
    if (op == OP_LW || op == OP_SW) begin
      v = vec(3'd4); v.mem_req = 1'b1; v.iord = 1'b1; v.mem_we = (op == OP_SW);
      r = v; r.retire = (op == OP_SW);
      access(v, r, wm, h);
      if (h) return;
    end
    if (op == OP_R || op == OP_ORI || op == OP_LW) begin
      v = vec(3'd5); v.reg_write = 1'b1; v.retire = 1'b1;
      v.reg_dst = (op == OP_R) ? 2'd1 : 2'd0;
      v.wb_sel  = (op == OP_LW) ? 2'd1 : 2'd0;
      cyc(rb(), rb(), v);
    end
  endtask

  // Reset asserted mid-cycle must show IDLE before the next clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    cyc(rb(), rb(), vec(3'd0));
    rst_n = 1'b1;
    cyc(rb(), rb(), vec(3'd0));
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 15))
      0, 1:    op = OP_R;
      2, 3:    op = OP_ORI;
      4, 5:    op = OP_LW;
      6, 7:    op = OP_SW;
      8, 9:    op = OP_BEQ;
      10, 11:  op = OP_J;
      12, 13:  op = OP_JAL;
      default: begin
        op = 6'h3f;
        for (int k = 0; k < 8; k++) begin
          op = 6'($urandom);
          if (!is_legal(op)) break;
        end
        if (is_legal(op)) op = 6'h3f;
      end
    endcase
    return op;
  endfunction

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, vec(3'd0));
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, vec(3'd0));

    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 1, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_JAL, 2, 0, 1'b0);
    run_instr(OP_SW, 0, 2, 1'b1);
    run_instr(OP_ORI, 3, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b1);

    for (int n = 0; n < 250; n++) begin
      op = pick_op();
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb());
      if (!is_legal(op)) do_reset();
    end

    // Illegal opcode halt, then reset recovery.
    run_instr(6'h3f, 0, 0, 1'b0);
    do_reset();

    // FETCH watchdog; the WAIT_LIMIT=0 instance must keep waiting.
    run_instr(OP_R, 20, 0, 1'b0);
    total++;
    if (d0_state !== 3'd1 || d0_mem_req !== 1'b1 || d0_halted !== 1'b0) begin
      bad++;
      $display("FAIL no_watchdog state=%0d mem_req=%0b halted=%0b required 1/1/0",
               d0_state, d0_mem_req, d0_halted);
    end
    do_reset();

    // mem_ready in the limit cycle wins.
    run_instr(OP_R, LIMIT - 1, 0, 1'b0);
    run_instr(OP_LW, 0, LIMIT - 1, 1'b0);
    // MEM watchdog.
    run_instr(OP_SW, 0, 9, 1'b0);
    do_reset();
    run_instr(OP_BEQ, 0, 0, 1'b1);

    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
